// File: rtl/riscv_ctrl_defs.sv
// Shared definitions for the RV32I multi-cycle control path: FSM state codes,
// opcodes, immediate formats, ALU operation codes and datapath mux selects.
package riscv_ctrl_defs;

   // FSM states in their fixed encoding order; codes 11-15 are unused.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_e;

   // Supported opcodes (instr[6:0]).
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // Immediate extender format selects.
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // ALUOp: what the controller asks of the ALU decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUControl: the operation the ALU performs.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ALU A operand select.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU B operand select.
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select.
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Memory address select.
   localparam logic ADR_PC     = 1'b0;
   localparam logic ADR_RESULT = 1'b1;

   // Moore control word: everything that depends only on the FSM state.
   typedef struct packed {
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] result_src;
      logic       adr_src;
      logic       ir_write;
      logic       pc_update;
      logic       branch;
      logic       reg_write;
      logic       mem_write;
      logic       done;
   } ctrl_t;

   // Control word asserted while the FSM sits in state s.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.adr_src    = ADR_PC;
            c.ir_write   = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALURESULT;
            c.pc_update  = 1'b1;
         end
         S_DECODE: begin
            // Precompute the branch/jump target OldPC + imm.
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = ADR_RESULT;
         end
         S_MEMWB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         S_MEMWRITE: begin
            c.result_src = RES_ALUOUT;
            c.adr_src    = ADR_RESULT;
            c.mem_write  = 1'b1;
            c.done       = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_RS2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.alu_src_a = SRCA_RS1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a  = SRCA_RS1;
            c.alu_src_b  = SRCB_RS2;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
            c.done       = 1'b1;
         end
         S_JAL: begin
            // PC <= target from DECODE while OldPC + 4 becomes the link value.
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_update  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // True for the opcodes this controller can execute.
   function automatic logic is_supported(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
             (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: turns ALUOp plus the instruction's funct fields into the ALU
// operation. Purely combinational; shared with the single-cycle core.
module alu_decoder
   import riscv_ctrl_defs::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   // Select the ALU operation from ALUOp and, for ALU instructions, funct3.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      alu_control_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_SUB: alu_control_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               // Only R-type (op[5]=1) can subtract; addi ignores funct7b5.
               3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         default: alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM controller for the multi-cycle RV32I core. Sequences fetch,
// decode, execute, memory and writeback over the shared ALU, memory and
// register file. STATE_W must be at least 4.
module multicycle_controller
   import riscv_ctrl_defs::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [6:0]         op,
   input  logic [2:0]         funct3,
   input  logic               funct7b5,
   input  logic               Zero,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ResultSrc,
   output logic [2:0]         ALUControl,
   output logic               AdrSrc,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_dbg
);

   state_e state_q, state_d;
   ctrl_t  ctrl_q;
   logic   illegal_decode;

   // Next-state logic; unused codes fall back to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // State register plus the control word for the state being entered, so
   // the Moore outputs come straight from flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         ctrl_q  <= state_ctrl(S_FETCH);
      end else begin
         // NOTE: non-blocking so state_q and ctrl_q both update from pre-edge values.
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
      end
   end

   // The instruction register loads at the end of FETCH, so an unsupported
   // opcode can only be seen in DECODE; flag it combinationally there.
   assign illegal_decode = (state_q == S_DECODE) && !is_supported(op);

   // Immediate format depends on the opcode alone, not on the state.
   always_comb begin
      ImmSrc = IMM_I;
      case (op)
         OP_SW:   ImmSrc = IMM_S;
         OP_BEQ:  ImmSrc = IMM_B;
         OP_JAL:  ImmSrc = IMM_J;
         default: ImmSrc = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op_i      (ctrl_q.alu_op),
      .funct3_i      (funct3),
      .op5_i         (op[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (ALUControl)
   );

   // Selects pass through; every enable is held low while reset is asserted
   // so an aborted instruction cannot write anything.
   assign ALUSrcA    = ctrl_q.alu_src_a;
   assign ALUSrcB    = ctrl_q.alu_src_b;
   assign ResultSrc  = ctrl_q.result_src;
   assign AdrSrc     = ctrl_q.adr_src;
   assign IRWrite    = reset_n & ctrl_q.ir_write;
   assign PCWrite    = reset_n & (ctrl_q.pc_update | (ctrl_q.branch & Zero));
   assign RegWrite   = reset_n & ctrl_q.reg_write;
   assign MemWrite   = reset_n & ctrl_q.mem_write;
   assign instr_done = reset_n & (ctrl_q.done | illegal_decode);
   assign illegal_op = reset_n & illegal_decode;
   assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instructions from
// the test plan, a mid-instruction reset, then randomized instruction streams
// compared each cycle against an instruction-level reference model.
module tb_multicycle_controller;

   // Opcodes as the ISA defines them, kept independent of the RTL package.
   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] JAL = 7'b1101111;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ALUControl;
   logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_op;
   logic [3:0] state_dbg;

   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_instr  = 0;
   string ctx      = "reset";

   typedef struct {
      logic [1:0] imm, srca, srcb, res;
      logic [2:0] aluc;
      logic       adr, irw, pcw, rw, mw, done, ill;
      logic [3:0] st;
   } exp_t;

   multicycle_controller #(.STATE_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .ImmSrc     (ImmSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s %s: got 0x%0h, expected 0x%0h", ctx, tag, obs, exp);
      else
         n_pass++;
   endtask

   function automatic bit legal(input logic [6:0] o);
      return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
   endfunction

   // Expected outputs while executing step s of an instruction (s is the
   // state number); last marks the instruction's final cycle.
   function automatic exp_t model(input int s, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input bit last);
      exp_t e;
      e.st   = 4'(s);
      e.imm  = (o == SW) ? 2'd1 : (o == BEQ) ? 2'd2 : (o == JAL) ? 2'd3 : 2'd0;
      e.srca = (s == 1 || s == 10) ? 2'd1 :
               (s == 2 || s == 6 || s == 7 || s == 9) ? 2'd2 : 2'd0;
      e.srcb = (s == 0 || s == 10) ? 2'd2 :
               (s == 1 || s == 2 || s == 7) ? 2'd1 : 2'd0;
      e.res  = (s == 0) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
      e.adr  = (s == 3 || s == 5);
      e.irw  = (s == 0);
      e.pcw  = (s == 0) || (s == 10) || (s == 9 && z);
      e.rw   = (s == 4 || s == 8);
      e.mw   = (s == 5);
      e.done = last;
      e.ill  = (s == 1) && !legal(o);
      if (s == 9)
         e.aluc = 3'b001;
      else if (s == 6 || s == 7) begin
         case (f3)
            3'b000:  e.aluc = (o == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  e.aluc = 3'b101;
            3'b110:  e.aluc = 3'b011;
            3'b111:  e.aluc = 3'b010;
            default: e.aluc = 3'b000;
         endcase
      end else
         e.aluc = 3'b000;
      return e;
   endfunction

   // While reset is held: FETCH selects, all enables low.
   function automatic exp_t reset_model(input logic [6:0] o);
      exp_t e;
      e = model(0, o, 3'b000, 1'b0, 1'b0, 1'b0);
      e.irw = 1'b0; e.pcw = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.done = 1'b0; e.ill = 1'b0;
      return e;
   endfunction

   task automatic compare_all(input exp_t e);
      check("state_dbg",  32'(state_dbg),  32'(e.st));
      check("ImmSrc",     32'(ImmSrc),     32'(e.imm));
      check("ALUSrcA",    32'(ALUSrcA),    32'(e.srca));
      check("ALUSrcB",    32'(ALUSrcB),    32'(e.srcb));
      check("ResultSrc",  32'(ResultSrc),  32'(e.res));
      check("ALUControl", 32'(ALUControl), 32'(e.aluc));
      check("AdrSrc",     32'(AdrSrc),     32'(e.adr));
      check("IRWrite",    32'(IRWrite),    32'(e.irw));
      check("PCWrite",    32'(PCWrite),    32'(e.pcw));
      check("RegWrite",   32'(RegWrite),   32'(e.rw));
      check("MemWrite",   32'(MemWrite),   32'(e.mw));
      check("instr_done", 32'(instr_done), 32'(e.done));
      check("illegal_op", 32'(illegal_op), 32'(e.ill));
   endtask

   // Runs one instruction (or its first `limit` cycles), starting just after
   // the edge that entered FETCH. zmode: 0/1 fixed Zero, 2 random per cycle.
   task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int zmode, input int limit);
      int path[$];
      op = o; funct3 = f3; funct7b5 = f7;
      case (o)
         LW:      path = '{0, 1, 2, 3, 4};
         SW:      path = '{0, 1, 2, 5};
         RT:      path = '{0, 1, 6, 8};
         IT:      path = '{0, 1, 7, 8};
         BEQ:     path = '{0, 1, 9};
         JAL:     path = '{0, 1, 10, 8};
         default: path = '{0, 1};
      endcase
      for (int k = 0; k < path.size() && k < limit; k++) begin
         Zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         @(negedge clk);
         ctx = $sformatf("instr%0d op=%b f3=%0d cyc%0d", n_instr, o, f3, k + 1);
         compare_all(model(path[k], o, f3, f7, Zero, k == path.size() - 1));
         @(posedge clk);
         #1;
      end
      n_instr++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [6:0] rop;
      reset_n = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

      // Reset held three cycles.
      repeat (3) begin
         @(negedge clk);
         ctx = "in reset";
         compare_all(reset_model(op));
      end
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Directed instructions from the test plan.
      run_instr(LW,  3'b010, 1'b0, 2, 99);
      run_instr(SW,  3'b010, 1'b0, 2, 99);
      run_instr(BEQ, 3'b000, 1'b0, 1, 99);
      run_instr(BEQ, 3'b000, 1'b0, 0, 99);
      run_instr(JAL, 3'b000, 1'b0, 2, 99);
      run_instr(RT,  3'b000, 1'b1, 2, 99);
      run_instr(RT,  3'b111, 1'b0, 2, 99);
      run_instr(RT,  3'b010, 1'b0, 2, 99);
      run_instr(IT,  3'b000, 1'b1, 2, 99);
      run_instr(7'b1111111, 3'b000, 1'b0, 2, 99);

      // Reset dropped in EXECUTER: immediate return to FETCH, no RegWrite.
      run_instr(RT, 3'b110, 1'b0, 2, 2);
      ctx = "before abort";
      check("state_dbg", 32'(state_dbg), 32'd6);
      #1 reset_n = 1'b0;
      #1 ctx = "abort asserted";
      compare_all(reset_model(RT));
      @(negedge clk);
      compare_all(reset_model(RT));
      @(posedge clk);
      #1 ctx = "abort next cycle";
      compare_all(reset_model(RT));
      reset_n = 1'b1;
      run_instr(RT, 3'b110, 1'b0, 2, 99);

      // Randomized instruction stream.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 6))
            0:       rop = LW;
            1:       rop = SW;
            2:       rop = RT;
            3:       rop = IT;
            4:       rop = BEQ;
            5:       rop = JAL;
            default: rop = 7'($urandom);
         endcase
         run_instr(rop, 3'($urandom), 1'($urandom), 2, 99);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
